sort_arbiter: RTL and testbench

Round-robin scheduler that shares one `insertionSort` engine between `NUM_REQ` requesters. Each requester presents a full array with a request/grant handshake. The arbiter sequences the engine (start, wait for done) and returns the sorted array, tagged with the requester ID, on a valid/ready response port. It sits between the client blocks and the single sort engine instance.

---
 rtl/sort_pkg.sv | 16 +
 rtl/rr_pick.sv | 38 +++
 rtl/sort_arbiter.sv | 164 ++++++++++++++++
 tb/tb_sort_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared types and default parameters for the sort arbiter
package sort_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_SIZE_DATA   = 8;
    localparam int DEF_NUMBER_ARR  = 8;
    localparam int DEF_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
//
// Ports:
//   req     - request vector, one bit per requester
//   last_id - index of the most recently granted requester
//   found   - at least one request is pending
//   idx     - first requesting index at or after last_id+1 (mod NUM_REQ)
module rr_pick
    import sort_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_id,
    output logic                       found,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] cand;

    // Walk from the farthest offset down to the nearest so the last hit
    // written is the closest requester after last_id.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = ID_W'((int'(last_id) + i) % NUM_REQ);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/sort_arbiter.sv
// rtl/sort_arbiter.sv - round-robin scheduler sharing one sort engine among requesters
//
// Optional feature macro: SORT_ARB_TIMEOUT_EN (WAIT-state watchdog).
//
// Ports:
//   i_clk, i_rst_n  - clock, asynchronous active-low reset
//   i_req, i_data   - per-requester level request and array
//   o_gnt           - one-hot single-cycle grant (array accepted)
//   o_rsp_*         - sorted array response, valid/ready, with requester id and error flag
//   o_eng_start     - engine start pulse
//   o_eng_data      - engine input array (hold register)
//   i_eng_data      - engine output array
//   i_eng_done      - engine done level; its rising edge completes a job
module sort_arbiter
    import sort_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int SIZE_DATA   = DEF_SIZE_DATA,
    parameter int NUMBER_ARR  = DEF_NUMBER_ARR,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                                          i_clk,
    input  logic                                          i_rst_n,
    input  logic [NUM_REQ-1:0]                            i_req,
    input  logic [NUM_REQ-1:0][NUMBER_ARR-1:0][SIZE_DATA-1:0] i_data,
    output logic [NUM_REQ-1:0]                            o_gnt,
    output logic                                          o_rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]                    o_rsp_id,
    output logic [NUMBER_ARR-1:0][SIZE_DATA-1:0]          o_rsp_data,
    output logic                                          o_rsp_err,
    input  logic                                          i_rsp_ready,
    output logic                                          o_eng_start,
    output logic [NUMBER_ARR-1:0][SIZE_DATA-1:0]          o_eng_data,
    input  logic [NUMBER_ARR-1:0][SIZE_DATA-1:0]          i_eng_data,
    input  logic                                          i_eng_done
);

    localparam int ID_W = $clog2(NUM_REQ);

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] cur_id;
    logic [ID_W-1:0] last_id;
    logic [ID_W-1:0] pick_idx;
    logic            pick_found;
    logic            done_q;
    logic            done_rise;

`ifdef SORT_ARB_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic        to_hit;
    logic        rsp_err_q;

    assign to_hit    = (to_cnt == 16'(TIMEOUT_CYC - 1));
    assign o_rsp_err = rsp_err_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYC;
    assign o_rsp_err      = 1'b0;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req     (i_req),
        .last_id (last_id),
        .found   (pick_found),
        .idx     (pick_idx)
    );

    // Only a 0->1 transition counts, so a done left high from the previous
    // job cannot complete the current one.
    assign done_rise = i_eng_done & ~done_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cur_id     <= '0;
            last_id    <= ID_W'(NUM_REQ - 1);
            done_q     <= 1'b0;
            o_eng_data <= '0;
            o_rsp_data <= '0;
            o_rsp_id   <= '0;
`ifdef SORT_ARB_TIMEOUT_EN
            to_cnt     <= '0;
            rsp_err_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            done_q  <= i_eng_done;
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        cur_id     <= pick_idx;
                        o_eng_data <= i_data[pick_idx];
                    end
                end
                START: begin
                    last_id <= cur_id;
`ifdef SORT_ARB_TIMEOUT_EN
                    to_cnt  <= '0;
`endif
                end
                WAIT: begin
                    if (done_rise) begin
                        o_rsp_data <= i_eng_data;
                        o_rsp_id   <= cur_id;
`ifdef SORT_ARB_TIMEOUT_EN
                        rsp_err_q  <= 1'b0;
                    end else if (to_hit) begin
                        // Engine is presumed hung: hand back the unsorted input.
                        o_rsp_data <= o_eng_data;
                        o_rsp_id   <= cur_id;
                        rsp_err_q  <= 1'b1;
                    end else begin
                        to_cnt     <= to_cnt + 16'd1;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        o_gnt       = '0;
        o_eng_start = 1'b0;
        o_rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = START;
                end
            end
            START: begin
                o_eng_start   = 1'b1;
                o_gnt[cur_id] = 1'b1;
                state_d       = WAIT;
            end
            WAIT: begin
                if (done_rise) begin
                    state_d = RESP;
                end
`ifdef SORT_ARB_TIMEOUT_EN
                else if (to_hit) begin
                    state_d = RESP;
                end
`endif
            end
            RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sort_arbiter.sv
// tb/tb_sort_arbiter.sv - self-checking bench for sort_arbiter with a behavioural sort engine
module tb_sort_arbiter;

    localparam int NR = 4;
    localparam int SD = 8;
    localparam int NA = 8;

    typedef logic [NA-1:0][SD-1:0] arr_t;
    typedef struct {
        logic [1:0] id;
        arr_t       data;
    } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic [NR-1:0]        req;
    logic [NR-1:0][NA-1:0][SD-1:0] in_data;
    logic [NR-1:0]        gnt;
    logic                 rsp_valid;
    logic [1:0]           rsp_id;
    arr_t                 rsp_data;
    logic                 rsp_err;
    logic                 rsp_ready;
    logic                 eng_start;
    arr_t                 eng_data;
    arr_t                 eng_out;
    logic                 eng_done;

    logic                 eng_en;
    logic                 eng_busy;
    int                   eng_cnt;

    exp_t                 exp_q[$];
    int                   tests = 0;
    int                   fails = 0;

    sort_arbiter #(
        .NUM_REQ     (NR),
        .SIZE_DATA   (SD),
        .NUMBER_ARR  (NA),
        .TIMEOUT_CYC (16)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_data      (in_data),
        .o_gnt       (gnt),
        .o_rsp_valid (rsp_valid),
        .o_rsp_id    (rsp_id),
        .o_rsp_data  (rsp_data),
        .o_rsp_err   (rsp_err),
        .i_rsp_ready (rsp_ready),
        .o_eng_start (eng_start),
        .o_eng_data  (eng_data),
        .i_eng_data  (eng_out),
        .i_eng_done  (eng_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic arr_t sort_arr(arr_t a);
        arr_t       r;
        logic [SD-1:0] t;
        r = a;
        for (int i = 0; i < NA - 1; i++) begin
            for (int j = 0; j < NA - 1 - i; j++) begin
                if (r[j] > r[j+1]) begin
                    t      = r[j];
                    r[j]   = r[j+1];
                    r[j+1] = t;
                end
            end
        end
        return r;
    endfunction

    function automatic arr_t rand_arr();
        arr_t r;
        for (int i = 0; i < NA; i++) r[i] = SD'($urandom) | 8'h01;
        return r;
    endfunction

    // Sort engine model: done pulses a few cycles after start unless disabled.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_busy <= 1'b0;
            eng_cnt  <= 0;
            eng_done <= 1'b0;
            eng_out  <= '0;
        end else begin
            eng_done <= 1'b0;
            if (eng_start) begin
                eng_busy <= 1'b1;
                eng_cnt  <= 4;
            end else if (eng_busy) begin
                if (eng_cnt == 0) begin
                    eng_busy <= 1'b0;
                    if (eng_en) begin
                        eng_done <= 1'b1;
                        eng_out  <= sort_arr(eng_data);
                    end
                end else begin
                    eng_cnt <= eng_cnt - 1;
                end
            end
        end
    end

    task automatic wait_gnt(output logic ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n++;
            if (gnt != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic get_rsp(output logic ok, output logic [1:0] id, output arr_t d, output logic err);
        ok  = 1'b0;
        id  = '0;
        d   = '0;
        err = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok  = 1'b1;
                id  = rsp_id;
                d   = rsp_data;
                err = rsp_err;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = '0;
        rsp_ready = 1'b1;
        eng_en    = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        in_data = '0;
        do_reset();
        tests++; if (gnt !== 4'b0) begin fails++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        tests++; if (eng_start !== 1'b0) begin fails++; $display("FAIL reset_start: got %b want 0", eng_start); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
        tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", rsp_err); end
        tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL reset_id: got %0d want 0", rsp_id); end
        tests++; if (rsp_data !== '0) begin fails++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        tests++; if (eng_data !== '0) begin fails++; $display("FAIL reset_eng_data: got %h want 0", eng_data); end
    endtask

    task automatic test_single();
        int   v[8] = '{7, 3, 5, 1, 8, 2, 6, 4};
        arr_t a;
        exp_t e;
        logic ok, err;
        logic [1:0] id;
        arr_t d;
        int   n;
        for (int i = 0; i < NA; i++) a[i] = SD'(v[i]);
        in_data[1] = a;
        exp_q.push_back('{id: 2'd1, data: sort_arr(a)});
        @(negedge clk);
        req[1] = 1'b1;
        wait_gnt(ok, n);
        tests++; if (!ok || n != 1) begin fails++; $display("FAIL single_gnt_latency: got ok=%0d n=%0d want n=1", ok, n); end
        tests++; if (gnt !== 4'b0010 || eng_start !== 1'b1) begin fails++; $display("FAIL single_gnt: got gnt=%b start=%b want 0010/1", gnt, eng_start); end
        req[1] = 1'b0;
        @(negedge clk);
        tests++; if (gnt !== 4'b0 || eng_start !== 1'b0) begin fails++; $display("FAIL single_gnt_pulse: got gnt=%b start=%b want 0000/0", gnt, eng_start); end
        get_rsp(ok, id, d, err);
        tests++;
        if (!ok) begin
            fails++; $display("FAIL single_rsp: no response within budget");
        end else begin
            e = exp_q.pop_front();
            if (id !== e.id || d !== e.data || err !== 1'b0) begin
                fails++; $display("FAIL single_rsp: got id=%0d err=%b data=%h want id=%0d err=0 data=%h", id, err, d, e.id, e.data);
            end
            for (int i = 0; i < NA; i++) begin
                tests++;
                if (d[i] !== SD'(i + 1)) begin fails++; $display("FAIL single_elem%0d: got %0d want %0d", i, d[i], i + 1); end
            end
        end
    endtask

    task automatic test_all_four();
        arr_t a;
        exp_t e;
        logic ok, err;
        logic [1:0] id;
        arr_t d;
        int   n;
        do_reset();
        for (int k = 0; k < NR; k++) begin
            a = rand_arr();
            in_data[k] = a;
            exp_q.push_back('{id: 2'(k), data: sort_arr(a)});
        end
        @(negedge clk);
        req = 4'b1111;
        for (int k = 0; k < NR; k++) begin
            wait_gnt(ok, n);
            tests++; if (!ok || gnt !== (4'b0001 << k)) begin fails++; $display("FAIL all4_gnt%0d: got %b want %b", k, gnt, 4'b0001 << k); end
            req[k] = 1'b0;
            get_rsp(ok, id, d, err);
            tests++;
            if (!ok) begin
                fails++; $display("FAIL all4_rsp%0d: no response within budget", k);
            end else begin
                e = exp_q.pop_front();
                if (id !== e.id || d !== e.data || err !== 1'b0) begin
                    fails++; $display("FAIL all4_rsp%0d: got id=%0d err=%b data=%h want id=%0d err=0 data=%h", k, id, err, d, e.id, e.data);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        logic ok, err;
        logic [1:0] id;
        arr_t d;
        int   n;
        in_data[2] = rand_arr();
        in_data[3] = rand_arr();
        exp_q.push_back('{id: 2'd2, data: sort_arr(in_data[2])});
        exp_q.push_back('{id: 2'd3, data: sort_arr(in_data[3])});
        @(negedge clk);
        rsp_ready = 1'b0;
        req[2]    = 1'b1;
        wait_gnt(ok, n);
        tests++; if (!ok || gnt !== 4'b0100) begin fails++; $display("FAIL bp_gnt2: got %b want 0100", gnt); end
        req[2] = 1'b0;
        req[3] = 1'b1;
        get_rsp(ok, id, d, err);
        tests++; if (!ok) begin fails++; $display("FAIL bp_rsp: no response within budget"); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            tests++;
            if (rsp_valid !== 1'b1 || rsp_id !== id || rsp_data !== d || gnt !== 4'b0 || eng_start !== 1'b0) begin
                fails++; $display("FAIL bp_hold%0d: got valid=%b id=%0d gnt=%b start=%b want 1/%0d/0000/0", c, rsp_valid, rsp_id, gnt, eng_start, id);
            end
        end
        e = exp_q.pop_front();
        tests++; if (id !== e.id || d !== e.data || err !== 1'b0) begin fails++; $display("FAIL bp_rsp2: got id=%0d err=%b data=%h want id=%0d data=%h", id, err, d, e.id, e.data); end
        rsp_ready = 1'b1;
        wait_gnt(ok, n);
        tests++; if (!ok || gnt !== 4'b1000) begin fails++; $display("FAIL bp_gnt3: got %b want 1000", gnt); end
        req[3] = 1'b0;
        get_rsp(ok, id, d, err);
        e = exp_q.pop_front();
        tests++; if (!ok || id !== e.id || d !== e.data || err !== 1'b0) begin fails++; $display("FAIL bp_rsp3: got ok=%0d id=%0d data=%h want id=%0d data=%h", ok, id, d, e.id, e.data); end
    endtask

    task automatic test_fairness();
        exp_t e;
        logic ok, err;
        logic [1:0] id;
        arr_t d;
        int   n;
        int   want;
        do_reset();
        in_data[0] = rand_arr();
        in_data[2] = rand_arr();
        @(negedge clk);
        req = 4'b0101;
        for (int k = 0; k < 6; k++) begin
            want = (k % 2 == 0) ? 0 : 2;
            exp_q.push_back('{id: 2'(want), data: sort_arr(in_data[want])});
            wait_gnt(ok, n);
            tests++; if (!ok || gnt !== (4'b0001 << want)) begin fails++; $display("FAIL rr_gnt%0d: got %b want %b", k, gnt, 4'b0001 << want); end
            if (k > 0) begin
                tests++; if (n != 2) begin fails++; $display("FAIL rr_b2b_gap%0d: got %0d cycles want 2", k, n); end
            end
            get_rsp(ok, id, d, err);
            e = exp_q.pop_front();
            tests++; if (!ok || id !== e.id || d !== e.data || err !== 1'b0) begin fails++; $display("FAIL rr_rsp%0d: got ok=%0d id=%0d data=%h want id=%0d data=%h", k, ok, id, d, e.id, e.data); end
        end
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic ok, err;
        logic [1:0] id;
        arr_t d;
        int   n;
        do_reset();
        in_data[1] = rand_arr();
        eng_en = 1'b0;
        @(negedge clk);
        req[1] = 1'b1;
        wait_gnt(ok, n);
        tests++; if (!ok || gnt !== 4'b0010) begin fails++; $display("FAIL mid_gnt1: got %b want 0010", gnt); end
        req[1] = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if (gnt !== 4'b0 || eng_start !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 ||
            rsp_id !== 2'd0 || rsp_data !== '0 || eng_data !== '0) begin
            fails++; $display("FAIL mid_reset_outputs: got gnt=%b start=%b valid=%b err=%b id=%0d eng_data=%h want all zero", gnt, eng_start, rsp_valid, rsp_err, rsp_id, eng_data);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n  = 1'b1;
        eng_en = 1'b1;
        in_data[0] = rand_arr();
        in_data[2] = rand_arr();
        exp_q.push_back('{id: 2'd0, data: sort_arr(in_data[0])});
        @(negedge clk);
        req = 4'b0101;
        wait_gnt(ok, n);
        tests++; if (!ok || gnt !== 4'b0001) begin fails++; $display("FAIL mid_gnt_after: got %b want 0001", gnt); end
        req = '0;
        get_rsp(ok, id, d, err);
        e = exp_q.pop_front();
        tests++; if (!ok || id !== e.id || d !== e.data || err !== 1'b0) begin fails++; $display("FAIL mid_rsp: got ok=%0d id=%0d data=%h want id=%0d data=%h", ok, id, d, e.id, e.data); end
    endtask

`ifdef SORT_ARB_TIMEOUT_EN
    task automatic test_timeout();
        arr_t a;
        logic ok;
        int   n;
        do_reset();
        eng_en = 1'b0;
        a = rand_arr();
        in_data[3] = a;
        @(negedge clk);
        req[3] = 1'b1;
        wait_gnt(ok, n);
        tests++; if (!ok || gnt !== 4'b1000) begin fails++; $display("FAIL to_gnt: got %b want 1000", gnt); end
        req[3] = 1'b0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (rsp_valid) break;
        end
        tests++; if (rsp_valid !== 1'b1 || n != 17) begin fails++; $display("FAIL to_latency: got valid=%b after %0d cycles want 1 after 17", rsp_valid, n); end
        tests++; if (rsp_err !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== a) begin fails++; $display("FAIL to_rsp: got err=%b id=%0d data=%h want 1/3/%h", rsp_err, rsp_id, rsp_data, a); end
        do_reset();
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        rsp_ready = 1'b1;
        eng_en    = 1'b1;
        in_data   = '0;
        test_reset();
        test_single();
        test_all_four();
        test_backpressure();
        test_fairness();
        test_reset_mid();
`ifdef SORT_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
